// File: rtl/regn_univ.sv
// regn_univ: WIDTH-bit universal register (hold/load/shift/rotate/inc/dec) with carry, zero and serial-out flags.
// Define REGN_PARITY_EN to build the registered even-parity output par_o; otherwise par_o is tied to 0.
module regn_univ #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             clr_b_i,
    input  logic             en_i,
    input  logic [2:0]       mode_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             sin_r_i,
    input  logic             sin_l_i,
    output logic [WIDTH-1:0] q_o,
    output logic             sout_l_o,
    output logic             sout_r_o,
    output logic             carry_o,
    output logic             zero_o,
    output logic             par_o
);
    logic [WIDTH-1:0] q_q, q_d;
    logic             carry_q, carry_d;
    logic [WIDTH:0]   inc_w, dec_w;
    always_comb begin
        inc_w   = {1'b0, q_q} + {{WIDTH{1'b0}}, 1'b1};
        dec_w   = {1'b0, q_q} - {{WIDTH{1'b0}}, 1'b1};
        q_d     = q_q;
        carry_d = carry_q;
        case (mode_i)
            3'b001: begin q_d = d_i;                          carry_d = 1'b0;           end
            3'b010: begin q_d = {q_q[WIDTH-2:0], sin_r_i};    carry_d = q_q[WIDTH-1];   end
            3'b011: begin q_d = {sin_l_i, q_q[WIDTH-1:1]};    carry_d = q_q[0];         end
            3'b100: begin q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]}; carry_d = q_q[WIDTH-1]; end
            3'b101: begin q_d = {q_q[0], q_q[WIDTH-1:1]};     carry_d = q_q[0];         end
            3'b110: begin q_d = inc_w[WIDTH-1:0];             carry_d = inc_w[WIDTH];   end
            3'b111: begin q_d = dec_w[WIDTH-1:0];             carry_d = dec_w[WIDTH];   end
            default: ;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (!clr_b_i) begin
            q_q     <= RESET_VAL;
            carry_q <= 1'b0;
        end else if (en_i) begin
            q_q     <= q_d;
            carry_q <= carry_d;
        end
    end
`ifdef REGN_PARITY_EN
    logic par_q;
    // Parity tracks the value being written so it never lags Q.
    always_ff @(posedge clk_i) begin
        if (!clr_b_i) par_q <= ^RESET_VAL;
        else if (en_i) par_q <= ^q_d;
    end
    assign par_o = par_q;
`else
    assign par_o = 1'b0;
`endif
    assign q_o      = q_q;
    assign carry_o  = carry_q;
    assign sout_l_o = q_q[WIDTH-1];
    assign sout_r_o = q_q[0];
    assign zero_o   = ~|q_q;
endmodule

// File: tb/tb_regn_univ.sv
// tb_regn_univ: directed vector table on a 4-bit instance plus randomised model comparison at widths 8 and 32.
module tb_regn_univ;
`ifdef REGN_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif
    localparam logic [7:0]  RV8  = 8'hA5;
    localparam logic [31:0] RV32 = 32'hDEADBEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_clr, a_en, a_sr, a_sl;
    logic [2:0] a_mode;
    logic [3:0] a_d, a_q;
    logic       a_soutl, a_soutr, a_cy, a_z, a_p;

    logic        b_clr, b_en, b_sr, b_sl;
    logic [2:0]  b_mode;
    logic [7:0]  b_d, b_q;
    logic        b_soutl, b_soutr, b_cy, b_z, b_p;

    logic        c_clr, c_en, c_sr, c_sl;
    logic [2:0]  c_mode;
    logic [31:0] c_d, c_q;
    logic        c_soutl, c_soutr, c_cy, c_z, c_p;

    regn_univ #(.WIDTH(4), .RESET_VAL(4'h5)) dut4 (
        .clk_i(clk), .clr_b_i(a_clr), .en_i(a_en), .mode_i(a_mode), .d_i(a_d),
        .sin_r_i(a_sr), .sin_l_i(a_sl), .q_o(a_q), .sout_l_o(a_soutl), .sout_r_o(a_soutr),
        .carry_o(a_cy), .zero_o(a_z), .par_o(a_p));
    regn_univ #(.WIDTH(8), .RESET_VAL(RV8)) dut8 (
        .clk_i(clk), .clr_b_i(b_clr), .en_i(b_en), .mode_i(b_mode), .d_i(b_d),
        .sin_r_i(b_sr), .sin_l_i(b_sl), .q_o(b_q), .sout_l_o(b_soutl), .sout_r_o(b_soutr),
        .carry_o(b_cy), .zero_o(b_z), .par_o(b_p));
    regn_univ #(.WIDTH(32), .RESET_VAL(RV32)) dut32 (
        .clk_i(clk), .clr_b_i(c_clr), .en_i(c_en), .mode_i(c_mode), .d_i(c_d),
        .sin_r_i(c_sr), .sin_l_i(c_sl), .q_o(c_q), .sout_l_o(c_soutl), .sout_r_o(c_soutr),
        .carry_o(c_cy), .zero_o(c_z), .par_o(c_p));

    int n_tot = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", nm, act, exp);
    endtask

    function automatic void model(input int w, input logic [2:0] m, input logic [31:0] d,
                                  input logic sr, input logic sl,
                                  inout logic [31:0] q, inout logic c);
        logic [31:0] mask;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        case (m)
            3'd1: begin c = 1'b0;     q = d & mask; end
            3'd2: begin c = q[w-1];   q = ((q << 1) | {31'b0, sr}) & mask; end
            3'd3: begin c = q[0];     q = (q >> 1) | ({31'b0, sl} << (w - 1)); end
            3'd4: begin c = q[w-1];   q = ((q << 1) | {31'b0, q[w-1]}) & mask; end
            3'd5: begin c = q[0];     q = (q >> 1) | ({31'b0, q[0]} << (w - 1)); end
            3'd6: begin c = (q == mask); q = (q + 32'd1) & mask; end
            3'd7: begin c = (q == 32'd0); q = (q - 32'd1) & mask; end
            default: ;
        endcase
    endfunction

    typedef struct {
        logic       clr, en;
        logic [2:0] mode;
        logic [3:0] d;
        logic       sr, sl;
        logic [3:0] q;
        logic       c;
    } vec_t;
    vec_t v[25];

    initial begin
        logic [31:0] mq8, mq32;
        logic        mc8, mc32;
        v[0]  = '{1'b0, 1'b1, 3'd6, 4'h0, 1'b0, 1'b0, 4'h5, 1'b0};
        v[1]  = '{1'b1, 1'b1, 3'd1, 4'hE, 1'b0, 1'b0, 4'hE, 1'b0};
        v[2]  = '{1'b1, 1'b0, 3'd1, 4'hB, 1'b0, 1'b0, 4'hE, 1'b0};
        v[3]  = '{1'b1, 1'b1, 3'd0, 4'hB, 1'b0, 1'b0, 4'hE, 1'b0};
        v[4]  = '{1'b1, 1'b1, 3'd1, 4'hB, 1'b0, 1'b0, 4'hB, 1'b0};
        v[5]  = '{1'b1, 1'b1, 3'd2, 4'h0, 1'b0, 1'b0, 4'h6, 1'b1};
        v[6]  = '{1'b1, 1'b1, 3'd3, 4'h0, 1'b0, 1'b1, 4'hB, 1'b0};
        v[7]  = '{1'b1, 1'b1, 3'd5, 4'h0, 1'b1, 1'b1, 4'hD, 1'b1};
        v[8]  = '{1'b1, 1'b1, 3'd4, 4'h0, 1'b0, 1'b0, 4'hB, 1'b1};
        v[9]  = '{1'b1, 1'b1, 3'd1, 4'hE, 1'b0, 1'b0, 4'hE, 1'b0};
        v[10] = '{1'b1, 1'b1, 3'd6, 4'h0, 1'b0, 1'b0, 4'hF, 1'b0};
        v[11] = '{1'b1, 1'b1, 3'd6, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1};
        v[12] = '{1'b1, 1'b1, 3'd7, 4'h0, 1'b0, 1'b0, 4'hF, 1'b1};
        v[13] = '{1'b1, 1'b1, 3'd1, 4'h3, 1'b0, 1'b0, 4'h3, 1'b0};
        v[14] = '{1'b1, 1'b1, 3'd1, 4'h4, 1'b0, 1'b0, 4'h4, 1'b0};
        v[15] = '{1'b1, 1'b1, 3'd6, 4'h0, 1'b0, 1'b0, 4'h5, 1'b0};
        v[16] = '{1'b0, 1'b1, 3'd3, 4'h0, 1'b0, 1'b0, 4'h5, 1'b0};
        v[17] = '{1'b1, 1'b0, 3'd6, 4'h0, 1'b0, 1'b0, 4'h5, 1'b0};
        v[18] = '{1'b1, 1'b1, 3'd7, 4'h0, 1'b0, 1'b0, 4'h4, 1'b0};
        v[19] = '{1'b1, 1'b1, 3'd2, 4'h0, 1'b1, 1'b0, 4'h9, 1'b0};
        v[20] = '{1'b1, 1'b1, 3'd3, 4'h0, 1'b1, 1'b0, 4'h4, 1'b1};
        v[21] = '{1'b1, 1'b1, 3'd1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0};
        v[22] = '{1'b1, 1'b1, 3'd7, 4'h0, 1'b0, 1'b0, 4'hF, 1'b1};
        v[23] = '{1'b1, 1'b0, 3'd1, 4'h0, 1'b0, 1'b0, 4'hF, 1'b1};
        v[24] = '{1'b1, 1'b1, 3'd0, 4'h0, 1'b0, 1'b0, 4'hF, 1'b1};

        {b_clr, b_en, b_mode, b_d, b_sr, b_sl} = '0;
        {c_clr, c_en, c_mode, c_d, c_sr, c_sl} = '0;
        {a_clr, a_en, a_mode, a_d, a_sr, a_sl} = '0;

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            {a_clr, a_en, a_mode, a_d, a_sr, a_sl} = {v[i].clr, v[i].en, v[i].mode, v[i].d, v[i].sr, v[i].sl};
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d q", i), 64'(a_q), 64'(v[i].q));
            chk($sformatf("vec%0d flags c/z/p/sl/sr", i), 64'({a_cy, a_z, a_p, a_soutl, a_soutr}),
                64'({v[i].c, v[i].q == 4'h0, PAR_ON & ^v[i].q, v[i].q[3], v[i].q[0]}));
        end

        // Reset is sampled only at the edge: a mid-cycle low changes nothing yet.
        @(negedge clk);
        a_clr = 1'b0; a_en = 1'b0;
        #2;
        chk("async clr low", 64'({a_q, a_cy}), 64'({4'hF, 1'b1}));
        @(posedge clk); #1;
        chk("clr edge", 64'({a_q, a_cy, a_p}), 64'({4'h5, 1'b0, PAR_ON & 1'b0}));
        @(negedge clk);
        a_clr = 1'b1; a_en = 1'b1; a_mode = 3'd6;
        #1;
        chk("clr release hold", 64'(a_q), 64'(4'h5));
        @(posedge clk); #1;
        chk("resume inc", 64'({a_q, a_cy, a_p}), 64'({4'h6, 1'b0, 1'b0}));

        mq8 = '0; mq32 = '0; mc8 = 1'b0; mc32 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            b_clr = (i == 0) ? 1'b0 : ($urandom_range(0, 19) != 0);
            b_en = ($urandom_range(0, 5) != 0);
            b_mode = 3'($urandom_range(0, 7));
            b_d = 8'($urandom);
            b_sr = 1'($urandom); b_sl = 1'($urandom);
            c_clr = (i == 0) ? 1'b0 : ($urandom_range(0, 19) != 0);
            c_en = ($urandom_range(0, 5) != 0);
            c_mode = 3'($urandom_range(0, 7));
            c_d = (i % 7 == 3) ? 32'hFFFF_FFFF : ((i % 11 == 5) ? 32'h0 : $urandom);
            c_sr = 1'($urandom); c_sl = 1'($urandom);
            @(posedge clk);
            if (!b_clr) begin mq8 = 32'(RV8); mc8 = 1'b0; end
            else if (b_en) model(8, b_mode, 32'(b_d), b_sr, b_sl, mq8, mc8);
            if (!c_clr) begin mq32 = RV32; mc32 = 1'b0; end
            else if (c_en) model(32, c_mode, c_d, c_sr, c_sl, mq32, mc32);
            #1;
            chk($sformatf("rnd8 cyc%0d", i), 64'({b_q, b_cy, b_z, b_p, b_soutl, b_soutr}),
                64'({mq8[7:0], mc8, mq8[7:0] == 8'h0, PAR_ON & ^mq8[7:0], mq8[7], mq8[0]}));
            chk($sformatf("rnd32 cyc%0d", i), 64'({c_q, c_cy, c_z, c_p, c_soutl, c_soutr}),
                64'({mq32, mc32, mq32 == 32'h0, PAR_ON & ^mq32, mq32[31], mq32[0]}));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
